// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between requesters, the arbiter and the grant consumer.
// The master side drives requests and ack; the slave side (the arbiter) presents the grant.
interface priority_arbiter_if #(
   parameter int NUM_REQUESTS = 4
) ();
   localparam int INDEX_WIDTH = $clog2(NUM_REQUESTS);

   logic [NUM_REQUESTS-1:0] requests;
   logic                    ack;
   logic                    valid;
   logic [NUM_REQUESTS-1:0] grant;
   logic [INDEX_WIDTH-1:0]  grant_index;

   modport master (
      output requests,
      output ack,
      input  valid,
      input  grant,
      input  grant_index
   );

   modport slave (
      input  requests,
      input  ack,
      output valid,
      output grant,
      output grant_index
   );
endinterface

// File: rtl/priority_arbiter.sv
// Fixed or rotating priority arbiter with a non-retracting registered grant.
// A grant is held until acked; an ack re-arbitrates in the same edge for bubble-free back-to-back grants.
module priority_arbiter #(
   parameter int NUM_REQUESTS = 4,
   parameter int ROUND_ROBIN  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   priority_arbiter_if.slave  bus
);
   localparam int INDEX_WIDTH = $clog2(NUM_REQUESTS);
   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_REQUESTS - 1);
   localparam logic [INDEX_WIDTH-1:0] ZERO_IDX = INDEX_WIDTH'(0);
   localparam logic [INDEX_WIDTH-1:0] ONE_IDX  = INDEX_WIDTH'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Pointer after acking grant g; in fixed mode it never leaves the top index.
   function automatic logic [INDEX_WIDTH-1:0] next_ptr(input logic [INDEX_WIDTH-1:0] g);
      logic [INDEX_WIDTH-1:0] res;
      if (ROUND_ROBIN == 0) begin
         res = LAST_IDX;
      end else if (g == ZERO_IDX) begin
         res = LAST_IDX;
      end else begin
         res = g - ONE_IDX;
      end
      return res;
   endfunction

   // Descending search starting at ptr, wrapping from 0 to the top index.
   function automatic logic [INDEX_WIDTH-1:0] pick(
      input logic [NUM_REQUESTS-1:0] req,
      input logic [INDEX_WIDTH-1:0]  ptr
   );
      logic [INDEX_WIDTH-1:0] idx;
      logic [INDEX_WIDTH-1:0] res;
      logic                   found;
      idx   = ptr;
      res   = ZERO_IDX;
      found = 1'b0;
      for (int k = 0; k < NUM_REQUESTS; k++) begin
         if (!found && req[idx]) begin
            res   = idx;
            found = 1'b1;
         end else begin
            res   = res;
         end
         idx = (idx == ZERO_IDX) ? LAST_IDX : (idx - ONE_IDX);
      end
      return res;
   endfunction

   function automatic logic [NUM_REQUESTS-1:0] decode(input logic [INDEX_WIDTH-1:0] idx);
      logic [NUM_REQUESTS-1:0] res;
      res      = {NUM_REQUESTS{1'b0}};
      res[idx] = 1'b1;
      return res;
   endfunction

   state_t                  state_q, state_d;
   logic                    valid_q, valid_d;
   logic [NUM_REQUESTS-1:0] grant_q, grant_d;
   logic [INDEX_WIDTH-1:0]  grant_index_q, grant_index_d;
   logic [INDEX_WIDTH-1:0]  ptr_q, ptr_d;

   logic                    any_req_s;
   logic [INDEX_WIDTH-1:0]  ack_ptr_s;
   logic [INDEX_WIDTH-1:0]  idle_winner_s;
   logic [INDEX_WIDTH-1:0]  ack_winner_s;

   // Arbitration candidates: from the held pointer when idle, from the updated pointer on an ack.
   always_comb begin
      any_req_s     = (bus.requests != {NUM_REQUESTS{1'b0}});
      ack_ptr_s     = next_ptr(grant_index_q);
      idle_winner_s = pick(bus.requests, ptr_q);
      ack_winner_s  = pick(bus.requests, ack_ptr_s);
   end

   // Next-state and next-output selection for the two-state grant controller.
   always_comb begin
      state_d       = state_q;
      valid_d       = valid_q;
      grant_d       = grant_q;
      grant_index_d = grant_index_q;
      ptr_d         = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req_s) begin
               state_d       = ST_GRANT;
               valid_d       = 1'b1;
               grant_index_d = idle_winner_s;
               grant_d       = decode(idle_winner_s);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (bus.ack && any_req_s) begin
               ptr_d         = ack_ptr_s;
               state_d       = ST_GRANT;
               valid_d       = 1'b1;
               grant_index_d = ack_winner_s;
               grant_d       = decode(ack_winner_s);
            end else if (bus.ack) begin
               ptr_d         = ack_ptr_s;
               state_d       = ST_IDLE;
               valid_d       = 1'b0;
               grant_index_d = ZERO_IDX;
               grant_d       = {NUM_REQUESTS{1'b0}};
            end else begin
               state_d = ST_GRANT;
            end
         end
         default: begin
            state_d       = ST_IDLE;
            valid_d       = 1'b0;
            grant_index_d = ZERO_IDX;
            grant_d       = {NUM_REQUESTS{1'b0}};
            ptr_d         = LAST_IDX;
         end
      endcase
   end

   // Controller state and registered outputs; reset discards any grant and restores fixed order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         valid_q       <= 1'b0;
         grant_q       <= {NUM_REQUESTS{1'b0}};
         grant_index_q <= ZERO_IDX;
         ptr_q         <= LAST_IDX;
      end else begin
         state_q       <= state_d;
         valid_q       <= valid_d;
         grant_q       <= grant_d;
         grant_index_q <= grant_index_d;
         ptr_q         <= ptr_d;
      end
   end

   assign bus.valid       = valid_q;
   assign bus.grant       = grant_q;
   assign bus.grant_index = grant_index_q;
endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter: a fixed-priority and a round-robin instance driven in lockstep
// and compared against a queue-free arbitration model built from modulo index arithmetic.
module tb_priority_arbiter;
   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] req_s = 4'b0000;
   logic       ack_s = 1'b0;

   int checks = 0;
   int passes = 0;

   // Model state per instance: index 0 = fixed priority, 1 = round robin.
   bit m_valid [2];
   int m_g     [2];
   int m_ptr   [2];

   priority_arbiter_if #(.NUM_REQUESTS(N)) if_fix ();
   priority_arbiter_if #(.NUM_REQUESTS(N)) if_rr ();

   assign if_fix.requests = req_s;
   assign if_fix.ack      = ack_s;
   assign if_rr.requests  = req_s;
   assign if_rr.ack       = ack_s;

   priority_arbiter #(.NUM_REQUESTS(N), .ROUND_ROBIN(0)) u_fix (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_fix.slave)
   );

   priority_arbiter #(.NUM_REQUESTS(N), .ROUND_ROBIN(1)) u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_rr.slave)
   );

   always #5 clk = ~clk;

   function automatic int ref_winner(input logic [3:0] req, input int ptr);
      int i;
      for (int k = 0; k < N; k++) begin
         i = (ptr - k + N) % N;
         if (req[i]) return i;
      end
      return 0;
   endfunction

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         m_valid[m] = 1'b0;
         m_g[m]     = 0;
         m_ptr[m]   = N - 1;
      end
   endfunction

   function automatic void model_edge(input logic [3:0] req, input logic a);
      for (int m = 0; m < 2; m++) begin
         if (!m_valid[m]) begin
            if (req != 4'b0000) begin
               m_g[m]     = ref_winner(req, m_ptr[m]);
               m_valid[m] = 1'b1;
            end
         end else if (a) begin
            m_ptr[m] = (m == 1) ? (m_g[m] + N - 1) % N : N - 1;
            if (req != 4'b0000) m_g[m] = ref_winner(req, m_ptr[m]);
            else m_valid[m] = 1'b0;
         end
      end
   endfunction

   // Packed view {valid, grant_index, grant}.
   function automatic logic [6:0] exp_pack(input int m);
      logic [3:0] g;
      logic [1:0] gi;
      g  = m_valid[m] ? (4'b0001 << m_g[m]) : 4'b0000;
      gi = m_valid[m] ? 2'(m_g[m]) : 2'b00;
      return {m_valid[m], gi, g};
   endfunction

   function automatic logic [6:0] obs_pack(input int m);
      if (m == 1) return {if_rr.valid, if_rr.grant_index, if_rr.grant};
      return {if_fix.valid, if_fix.grant_index, if_fix.grant};
   endfunction

   task automatic step(input logic [3:0] req, input logic a);
      req_s = req;
      ack_s = a;
      @(posedge clk);
      model_edge(req, a);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (obs_pack(m) !== 7'b0000000) $display("FAIL reset_async mode%0d: got %b want 0000000", m, obs_pack(m));
         else passes++;
      end
      req_s = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (obs_pack(m) !== 7'b0000000) $display("FAIL reset_held mode%0d: got %b want 0000000", m, obs_pack(m));
         else passes++;
      end
      req_s = 4'b0000;
      #3;
      rst_n = 1'b1;
   endtask

   task automatic test_idle_ack();
      for (int k = 0; k < 5; k++) begin
         step(4'b0000, 1'b1);
         checks++;
         if (if_rr.valid !== 1'b0 || if_fix.valid !== 1'b0)
            $display("FAIL idle_ack cycle %0d: got valid rr=%b fix=%b want 0", k, if_rr.valid, if_fix.valid);
         else passes++;
      end
      step(4'b1111, 1'b0);
      checks++;
      if (if_rr.grant_index !== 2'd3 || if_rr.valid !== 1'b1)
         $display("FAIL idle_ack_ptr: got idx=%0d valid=%b want idx=3 valid=1", if_rr.grant_index, if_rr.valid);
      else passes++;
      step(4'b0000, 1'b1);
   endtask

   task automatic test_fixed_hold();
      step(4'b0110, 1'b0);
      checks++;
      if (obs_pack(0) !== 7'b1_10_0100) $display("FAIL fixed_first: got %b want 1100100", obs_pack(0));
      else passes++;
      for (int k = 0; k < 10; k++) begin
         step(4'($urandom_range(0, 15)), 1'b0);
         checks++;
         if (obs_pack(0) !== 7'b1_10_0100 || obs_pack(1) !== exp_pack(1))
            $display("FAIL fixed_hold cycle %0d: got fix=%b rr=%b want fix=1100100 rr=%b", k, obs_pack(0), obs_pack(1), exp_pack(1));
         else passes++;
      end
      step(4'b0000, 1'b1);
      checks++;
      if (obs_pack(0) !== 7'b0000000 || obs_pack(1) !== 7'b0000000)
         $display("FAIL fixed_release: got fix=%b rr=%b want 0000000", obs_pack(0), obs_pack(1));
      else passes++;
   endtask

   task automatic test_rr_rotation();
      int seq [6] = '{3, 2, 1, 0, 3, 2};
      rst_n = 1'b0;
      model_reset();
      #2;
      rst_n = 1'b1;
      step(4'b1111, 1'b0);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) step(4'b1111, 1'b1);
         checks++;
         if (if_rr.grant_index !== 2'(seq[k]) || if_rr.valid !== 1'b1 || if_fix.grant_index !== 2'd3 ||
             obs_pack(1) !== exp_pack(1))
            $display("FAIL rr_rotation %0d: got rr idx=%0d valid=%b fix idx=%0d want rr idx=%0d valid=1 fix idx=3",
                     k, if_rr.grant_index, if_rr.valid, if_fix.grant_index, seq[k]);
         else passes++;
      end
      step(4'b0000, 1'b1);
   endtask

   task automatic test_rr_wrap();
      step(4'b0001, 1'b0);
      checks++;
      if (if_rr.grant_index !== 2'd0 || if_rr.grant !== 4'b0001)
         $display("FAIL rr_wrap_first: got idx=%0d grant=%b want idx=0 grant=0001", if_rr.grant_index, if_rr.grant);
      else passes++;
      step(4'b1001, 1'b1);
      checks++;
      if (if_rr.grant_index !== 2'd3 || if_rr.valid !== 1'b1 || obs_pack(0) !== exp_pack(0))
         $display("FAIL rr_wrap_next: got idx=%0d valid=%b fix=%b want idx=3 valid=1 fix=%b",
                  if_rr.grant_index, if_rr.valid, obs_pack(0), exp_pack(0));
      else passes++;
      step(4'b0000, 1'b1);
   endtask

   task automatic test_one_cycle_request();
      step(4'b0100, 1'b0);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step(4'b0000, 1'b0);
         for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs_pack(m) !== 7'b1_10_0100) $display("FAIL one_cycle_hold mode%0d cycle %0d: got %b want 1100100", m, k, obs_pack(m));
            else passes++;
         end
      end
      step(4'b0000, 1'b1);
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (obs_pack(m) !== 7'b0000000) $display("FAIL one_cycle_ack mode%0d: got %b want 0000000", m, obs_pack(m));
         else passes++;
      end
   endtask

   task automatic test_reset_mid_grant();
      step(4'b0100, 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (obs_pack(1) !== 7'b0000000 || obs_pack(0) !== 7'b0000000)
         $display("FAIL reset_mid_grant: got rr=%b fix=%b want 0000000", obs_pack(1), obs_pack(0));
      else passes++;
      #1;
      rst_n = 1'b1;
      step(4'b0011, 1'b0);
      checks++;
      if (if_rr.grant_index !== 2'd1 || if_rr.grant !== 4'b0010 || if_fix.grant_index !== 2'd1)
         $display("FAIL reset_first_arb: got rr idx=%0d grant=%b fix idx=%0d want idx=1 grant=0010",
                  if_rr.grant_index, if_rr.grant, if_fix.grant_index);
      else passes++;
      step(4'b0000, 1'b1);
   endtask

   task automatic test_random();
      logic [3:0] r;
      logic       a;
      int         bad = 0;
      for (int k = 0; k < 400; k++) begin
         r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         a = 1'($urandom_range(0, 1));
         step(r, a);
         for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs_pack(m) !== exp_pack(m)) begin
               if (bad < 10) $display("FAIL random mode%0d step %0d: got %b want %b", m, k, obs_pack(m), exp_pack(m));
               bad++;
            end else passes++;
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_idle_ack();
      test_fixed_hold();
      test_rr_rotation();
      test_rr_wrap();
      test_one_cycle_request();
      test_reset_mid_grant();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter NUM_REQUESTS, default 4, number of requesters; SHALL be >= 2.
REQ-002 Parameter ROUND_ROBIN, default 1; 0 = fixed priority, 1 = rotating priority.
REQ-003 Localparam INDEX_WIDTH = $clog2(NUM_REQUESTS).
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 requests  input  NUM_REQUESTS  request vector; bit i = requester i.
REQ-007 ack  input  1  consumer accepts the current grant this cycle.
REQ-008 valid  output  1  a grant is being presented.
REQ-009 grant  output  NUM_REQUESTS  one-hot grant; all zero when valid=0.
REQ-010 grant_index  output  INDEX_WIDTH  binary index of granted requester; 0 when valid=0.

Function
REQ-011 Two states SHALL exist: IDLE (valid=0) and GRANT (valid=1); all outputs SHALL be registered.
REQ-012 IDLE: at a rising edge where requests != 0, SHALL load the arbitration winner and enter GRANT; latency = 1 cycle from request to valid.
REQ-013 IDLE: at an edge where requests == 0, SHALL remain IDLE; ack SHALL be ignored with no state or pointer change.
REQ-014 GRANT with ack=0: grant, grant_index and valid SHALL hold unchanged regardless of request changes, including the granted request deasserting (no retraction).
REQ-015 GRANT with ack=1: SHALL update the priority pointer, then arbitrate the requests sampled at the same edge using the updated pointer.
REQ-016 Ack edge with requests != 0: SHALL stay in GRANT with the new winner, so valid stays high with no bubble (back-to-back grants).
REQ-017 Ack edge with requests == 0: SHALL enter IDLE; valid, grant and grant_index SHALL be 0 on the next cycle.
REQ-018 Fixed mode: winner SHALL be the highest asserted index.
REQ-019 Fixed mode: the pointer SHALL stay at NUM_REQUESTS-1.
REQ-020 Round-robin mode: pointer ptr (INDEX_WIDTH bits) SHALL give the highest-priority index.
REQ-021 Round-robin search order SHALL be ptr, ptr-1, ..., 0, NUM_REQUESTS-1, ..., ptr+1 (descending with wrap).
REQ-022 Round-robin: after an acked grant g, ptr SHALL be g-1; for g=0 it SHALL wrap to NUM_REQUESTS-1, making g the lowest priority.
REQ-023 Pointer arithmetic SHALL be modulo NUM_REQUESTS, including non-power-of-two values; ptr SHALL never hold a value >= NUM_REQUESTS.
REQ-024 grant SHALL always equal the one-hot decode of grant_index while valid=1.
REQ-025 Pointer SHALL change only on an ack edge in GRANT.

Reset
REQ-026 When rst_n=0, SHALL immediately force (asynchronously): state=IDLE, valid=0, grant=0, grant_index=0, ptr=NUM_REQUESTS-1.
REQ-027 Reset asserted mid-grant SHALL discard the grant with no pointer update; the first arbitration after release SHALL equal fixed-priority order.
REQ-028 Reset deassertion SHALL be sampled so that the first possible grant appears no earlier than 1 cycle after the first post-reset edge with requests != 0.

Verification (NUM_REQUESTS=4)
REQ-029 Fixed mode, requests=4'b0110, ack=0 -> next cycle valid=1, grant=4'b0100, grant_index=2, held for 10+ cycles.
REQ-030 RR mode, requests=4'b1111 constant, ack=1 every cycle -> grant_index sequence 3,2,1,0,3,2 with valid continuously 1.
REQ-031 RR mode wrap: requests=4'b0001 -> grant_index=0; then ack with requests=4'b1001 -> next grant_index=3 (ptr wrapped to 3).
REQ-032 Requests=4'b0100 for one cycle only -> grant_index=2 held until ack; ack with requests=0 -> next cycle valid=0, grant=0.
REQ-033 RR mode: grant index 2 active, rst_n pulsed low -> outputs 0 without a clock edge; after release, requests=4'b0011 -> grant_index=1.
REQ-034 IDLE, ack=1 for 5 cycles with requests=0 -> valid stays 0; then requests=4'b1111 in RR mode -> grant_index=3 (pointer unchanged).
